bsg_cache_nb_dma_initiator: RTL and testbench
=============================================

Name: bsg_cache_nb_dma_initiator

Overview:
- Cache-side initiator for the non-blocking cache DMA protocol, i.e. the end that issues requests and consumes responses.
- Turns refill and evict commands from the cache miss logic into DMA read packets and DMA write packets.
- Streams evict bursts out to memory.
- Collects returning refill bursts, tags each one with its MSHR id and burst index, and hands them to the fill path.
- Tracks outstanding refills per MSHR.

Parameters:
- addr_width_p, 32, byte address width.
- data_width_p, 32, cache word width.
- dma_data_width_p, 64, DMA burst width (multiple of data_width_p).
- block_size_in_words_p, 8, words per cache block.
- mask_width_p, 8, write-mask bits per block, one per word (must equal block_size_in_words_p).
- mshr_els_p, 4, number of MSHRs.
- bursts_lp, derived, block_size_in_words_p*data_width_p/dma_data_width_p; must be >= 2.
- timeout_p, 1024, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-low reset (0 = reset).
- cmd_v_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted when cmd_v_i & cmd_ready_o.
- cmd_write_i  in  1  1 = evict (write), 0 = refill (read).
- cmd_addr_i  in  addr_width_p  block address.
- cmd_mask_i  in  mask_width_p  word write mask (evict only).
- cmd_mshr_id_i  in  clog2(mshr_els_p)  MSHR id (refill only).
- dma_read_pkt_o  out  dma_pkt_width  read packet, built with declare_bsg_cache_nb_dma_pkt_s: addr, mask = 0, mshr_id.
- dma_read_pkt_v_o  out  1  read packet valid.
- dma_read_pkt_yumi_i  in  1  read packet taken.
- dma_write_pkt_o  out  dma_pkt_width  write packet: addr, mask, mshr_id = 0.
- dma_write_pkt_v_o  out  1  write packet valid.
- dma_write_pkt_yumi_i  in  1  write packet taken.
- dma_data_i  in  dma_data_width_p  refill burst.
- dma_mshr_id_i  in  clog2(mshr_els_p)  MSHR id of the refill burst.
- dma_data_v_i  in  1  refill burst valid.
- dma_data_ready_o  out  1  refill burst accepted when v & ready.
- dma_data_o  out  dma_data_width_p  evict burst to memory.
- dma_data_v_o  out  1  evict burst valid.
- dma_data_yumi_i  in  1  evict burst taken.
- evict_data_i  in  dma_data_width_p  evict burst from the data array.
- evict_data_v_i  in  1  evict burst available.
- evict_data_yumi_o  out  1  evict burst consumed.
- fill_data_o  out  dma_data_width_p  refill burst to the fill path.
- fill_mshr_id_o  out  clog2(mshr_els_p)  MSHR id of the fill burst.
- fill_burst_idx_o  out  clog2(bursts_lp)  index of the burst within the block.
- fill_last_o  out  1  final burst of the block.
- fill_v_o  out  1  fill burst valid.
- fill_ready_i  in  1  fill path ready.
- pending_o  out  mshr_els_p  per-MSHR outstanding-refill bits.
- error_o  out  1  sticky protocol error flag.

Behaviour:
- Reset (reset_i == 0, sampled at the clock edge):
  - Request FSM goes to IDLE; return and write counters clear; pending_o = 0; error_o = 0.
  - All v/yumi/ready outputs are 0 while reset is asserted and in the first cycle after it.
  - Reset during a transfer abandons it; no partial state survives.
- Request FSM states: IDLE, RD_REQ, WR_REQ, WR_DATA.
- IDLE:
  - cmd_ready_o = !cmd_write_i ? !pending_o[cmd_mshr_id_i] : 1. This is combinational from the cmd inputs.
  - On accept, latch addr, mask and mshr_id, then go to RD_REQ if the command is a refill, else WR_REQ.
- RD_REQ:
  - dma_read_pkt_v_o = 1 with latched fields, held stable until yumi.
  - On yumi, set pending_o[id] and return to IDLE.
- WR_REQ:
  - dma_write_pkt_v_o = 1; on yumi, clear the write counter and go to WR_DATA.
- WR_DATA:
  - dma_data_o = evict_data_i, dma_data_v_o = evict_data_v_i, evict_data_yumi_o = dma_data_yumi_i. This is a pass-through with 0 latency.
  - Each yumi increments the write counter.
  - The yumi at counter == bursts_lp-1 returns the FSM to IDLE.
  - Bursts are sent for masked-off words as well; memory applies the mask.
- Return path (independent of the FSM, may overlap with WR_DATA):
  - fill_data_o = dma_data_i, fill_mshr_id_o = dma_mshr_id_i, fill_v_o = dma_data_v_i, dma_data_ready_o = fill_ready_i. Latency is 0.
  - rx counter: fill_burst_idx_o = rx counter; fill_last_o = (rx counter == bursts_lp-1).
  - On v & ready, the counter increments; on the last burst it wraps to 0 and clears pending_o[id].
- Error conditions (set error_o, stay set until reset, $error in simulation):
  - a burst arrives for an MSHR that is not pending;
  - the MSHR id changes mid-block (rx counter != 0 and the id differs from the latched id).
- A burst completing the same cycle that a new refill for that id is accepted cannot happen: the id is still pending that cycle, so cmd_ready_o is 0.
- A packet yumi and a last-burst completion in the same cycle for different ids both take effect.

Optional Feature:
- BSG_CACHE_NB_DMA_INITIATOR_TIMEOUT_EN defined:
  - one watchdog counter runs whenever pending_o != 0 and resets on any accepted refill burst.
  - Reaching timeout_p sets error_o and issues $error.
- Undefined: no watchdog logic; a timeout never sets error_o.

Test Plan:
- Refill addr 0x1000, id 2, memory yumi after 3 cycles -> read pkt addr 0x1000, id 2; pending_o = 4'b0100; 4 fill bursts with idx 0..3, last on idx 3; pending_o = 0 afterwards.
- Evict addr 0x2040, mask 8'hF0, evict_data_v_i gapped 1-of-2 cycles -> write pkt mask 8'hF0; exactly 4 data bursts in order; FSM back to IDLE after the 4th yumi.
- Refill ids 0, 1 and 3 back-to-back, then a refill to id 1 again -> the 4th cmd_ready_o stays 0 until id 1's last burst is accepted.
- fill_ready_i toggled randomly during a refill -> no burst lost or duplicated; idx increments only on v & ready.
- Burst arrives with id 3 while nothing is pending -> error_o rises the next cycle and stays 1 until reset.
- reset_i = 0 during burst idx 2 of a refill -> pending_o = 0, counters 0, all valids 0; a new refill then completes normally.

Source files
------------

// File: rtl/bsg_cache_nb_dma_initiator.sv
// bsg_cache_nb_dma_initiator
// Cache-side end of the non-blocking cache DMA protocol. Refill and evict
// commands become DMA read and write packets. Evict bursts stream from the
// data array to memory with no added latency. Returning refill bursts are
// tagged with their MSHR id and burst index and passed to the fill path.
// Outstanding refills are tracked per MSHR, and protocol violations raise a
// sticky error flag.
// Optional feature: define BSG_CACHE_NB_DMA_INITIATOR_TIMEOUT_EN to add a
// watchdog that flags an error when refills stall for timeout_p cycles.
module bsg_cache_nb_dma_initiator #(
  parameter int addr_width_p          = 32,
  parameter int data_width_p          = 32,
  parameter int dma_data_width_p      = 64,
  parameter int block_size_in_words_p = 8,
  parameter int mask_width_p          = 8,
  parameter int mshr_els_p            = 4,
  parameter int timeout_p             = 1024,
  parameter bit err_report_p          = 1'b1,
  localparam int id_width_lp   = (mshr_els_p > 1) ? $clog2(mshr_els_p) : 1,
  localparam int bursts_lp     = block_size_in_words_p * data_width_p / dma_data_width_p,
  localparam int idx_width_lp  = (bursts_lp > 1) ? $clog2(bursts_lp) : 1,
  localparam int dma_pkt_width = addr_width_p + mask_width_p + id_width_lp
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        cmd_v_i,
  output logic                        cmd_ready_o,
  input  logic                        cmd_write_i,
  input  logic [addr_width_p-1:0]     cmd_addr_i,
  input  logic [mask_width_p-1:0]     cmd_mask_i,
  input  logic [id_width_lp-1:0]      cmd_mshr_id_i,
  output logic [dma_pkt_width-1:0]    dma_read_pkt_o,
  output logic                        dma_read_pkt_v_o,
  input  logic                        dma_read_pkt_yumi_i,
  output logic [dma_pkt_width-1:0]    dma_write_pkt_o,
  output logic                        dma_write_pkt_v_o,
  input  logic                        dma_write_pkt_yumi_i,
  input  logic [dma_data_width_p-1:0] dma_data_i,
  input  logic [id_width_lp-1:0]      dma_mshr_id_i,
  input  logic                        dma_data_v_i,
  output logic                        dma_data_ready_o,
  output logic [dma_data_width_p-1:0] dma_data_o,
  output logic                        dma_data_v_o,
  input  logic                        dma_data_yumi_i,
  input  logic [dma_data_width_p-1:0] evict_data_i,
  input  logic                        evict_data_v_i,
  output logic                        evict_data_yumi_o,
  output logic [dma_data_width_p-1:0] fill_data_o,
  output logic [id_width_lp-1:0]      fill_mshr_id_o,
  output logic [idx_width_lp-1:0]     fill_burst_idx_o,
  output logic                        fill_last_o,
  output logic                        fill_v_o,
  input  logic                        fill_ready_i,
  output logic [mshr_els_p-1:0]       pending_o,
  output logic                        error_o
);

  // Packet layout: address in the upper bits, then word mask, then MSHR id.
  typedef struct packed {
    logic [addr_width_p-1:0] addr;
    logic [mask_width_p-1:0] mask;
    logic [id_width_lp-1:0]  mshr_id;
  } dma_pkt_s;

  typedef enum logic [1:0] {S_IDLE, S_RD_REQ, S_WR_REQ, S_WR_DATA} state_e;

  localparam logic [idx_width_lp-1:0] last_idx_lp = idx_width_lp'(bursts_lp - 1);

  if (bursts_lp < 2 || mask_width_p != block_size_in_words_p || timeout_p < 1) begin : g_bad_cfg
    $error("bsg_cache_nb_dma_initiator: illegal parameter combination");
  end

  state_e                  r_state;
  logic                    r_live;
  logic                    r_read_v;
  logic                    r_write_v;
  logic [addr_width_p-1:0] r_addr;
  logic [mask_width_p-1:0] r_mask;
  logic [id_width_lp-1:0]  r_id;
  logic [idx_width_lp-1:0] r_wr_cnt;
  logic [idx_width_lp-1:0] r_rx_cnt;
  logic [id_width_lp-1:0]  r_rx_id;
  logic [mshr_els_p-1:0]   r_pending;
  logic                    r_error;

  logic                    w_live;
  logic                    w_cmd_fire;
  logic                    w_rd_yumi;
  logic                    w_in_wr_data;
  logic                    w_wd_fire;
  logic                    w_rx_fire;
  logic                    w_rx_last;
  logic                    w_err_set;
  logic                    w_wd_expire;
  logic [mshr_els_p-1:0]   w_pend_set;
  logic [mshr_els_p-1:0]   w_pend_clr;
  dma_pkt_s                w_read_pkt;
  dma_pkt_s                w_write_pkt;

  // Handshakes stay low during reset and for one cycle after it.
  assign w_live       = r_live & reset_i;
  assign cmd_ready_o  = w_live && (r_state == S_IDLE)
                        && (cmd_write_i || !r_pending[cmd_mshr_id_i]);
  assign w_cmd_fire   = cmd_v_i & cmd_ready_o;
  assign w_rd_yumi    = r_read_v & dma_read_pkt_yumi_i;

  assign dma_read_pkt_v_o  = r_read_v & reset_i;
  assign dma_write_pkt_v_o = r_write_v & reset_i;

  // Evict data passes straight from the data array to memory.
  assign w_in_wr_data      = w_live && (r_state == S_WR_DATA);
  assign dma_data_o        = evict_data_i;
  assign dma_data_v_o      = w_in_wr_data & evict_data_v_i;
  assign evict_data_yumi_o = w_in_wr_data & dma_data_yumi_i;
  assign w_wd_fire         = evict_data_yumi_o;

  // Refill data passes straight to the fill path, tagged with its index.
  assign fill_data_o      = dma_data_i;
  assign fill_mshr_id_o   = dma_mshr_id_i;
  assign fill_v_o         = w_live & dma_data_v_i;
  assign dma_data_ready_o = w_live & fill_ready_i;
  assign fill_burst_idx_o = r_rx_cnt;
  assign w_rx_last        = (r_rx_cnt == last_idx_lp);
  assign fill_last_o      = w_rx_last;
  assign w_rx_fire        = fill_v_o & dma_data_ready_o;

  assign pending_o = r_pending;
  assign error_o   = r_error;

  // Packet assembly and per-MSHR pending set/clear masks.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_read_pkt          = '0;
    w_read_pkt.addr     = r_addr;
    w_read_pkt.mshr_id  = r_id;
    w_write_pkt         = '0;
    w_write_pkt.addr    = r_addr;
    w_write_pkt.mask    = r_mask;
    w_pend_set          = '0;
    w_pend_clr          = '0;
    if (w_rd_yumi)              w_pend_set[r_id]          = 1'b1;
    if (w_rx_fire && w_rx_last) w_pend_clr[dma_mshr_id_i] = 1'b1;
  end

  assign dma_read_pkt_o  = w_read_pkt;
  assign dma_write_pkt_o = w_write_pkt;

  assign w_err_set = (w_rx_fire && !r_pending[dma_mshr_id_i])
                  || (w_rx_fire && (r_rx_cnt != '0) && (dma_mshr_id_i != r_rx_id))
                  || w_wd_expire;

  // Tracks the cycle after reset so handshakes open one cycle late.
  always_ff @(posedge clk_i) begin
    // NOTE: reset is synchronous and active-low: it only acts at a clock edge, inside the clocked block.
    if (!reset_i) r_live <= 1'b0;
    else          r_live <= 1'b1;
  end

  // Request FSM: command accept, packet handshakes and evict burst count.
  always_ff @(posedge clk_i) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset_i) begin
      r_state   <= S_IDLE;
      r_read_v  <= 1'b0;
      r_write_v <= 1'b0;
      r_addr    <= '0;
      r_mask    <= '0;
      r_id      <= '0;
      r_wr_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_cmd_fire) begin
          r_addr <= cmd_addr_i;
          r_mask <= cmd_mask_i;
          r_id   <= cmd_mshr_id_i;
          if (cmd_write_i) begin
            r_state   <= S_WR_REQ;
            r_write_v <= 1'b1;
          end else begin
            r_state  <= S_RD_REQ;
            r_read_v <= 1'b1;
          end
        end
        S_RD_REQ: if (dma_read_pkt_yumi_i) begin
          r_read_v <= 1'b0;
          r_state  <= S_IDLE;
        end
        S_WR_REQ: if (dma_write_pkt_yumi_i) begin
          r_write_v <= 1'b0;
          r_wr_cnt  <= '0;
          r_state   <= S_WR_DATA;
        end
        S_WR_DATA: if (w_wd_fire) begin
          r_wr_cnt <= r_wr_cnt + 1'b1;
          if (r_wr_cnt == last_idx_lp) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Return path: burst counter, block owner, pending bits and sticky error.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_rx_cnt  <= '0;
      r_rx_id   <= '0;
      r_pending <= '0;
      r_error   <= 1'b0;
    end else begin
      if (w_rx_fire) begin
        r_rx_cnt <= w_rx_last ? '0 : r_rx_cnt + 1'b1;
        if (r_rx_cnt == '0) r_rx_id <= dma_mshr_id_i;
      end
      r_pending <= (r_pending & ~w_pend_clr) | w_pend_set;
      if (w_err_set) r_error <= 1'b1;
    end
  end

`ifdef BSG_CACHE_NB_DMA_INITIATOR_TIMEOUT_EN
  localparam int wd_width_lp = $clog2(timeout_p + 1);
  logic [wd_width_lp-1:0] r_wd_cnt;

  assign w_wd_expire = (r_wd_cnt == wd_width_lp'(timeout_p));

  // Watchdog: counts while any refill is outstanding, restarts on each burst.
  always_ff @(posedge clk_i) begin
    if (!reset_i)                         r_wd_cnt <= '0;
    else if (w_rx_fire || r_pending == '0) r_wd_cnt <= '0;
    else if (!w_wd_expire)                 r_wd_cnt <= r_wd_cnt + 1'b1;
  end
`else
  assign w_wd_expire = 1'b0;
`endif

`ifndef SYNTHESIS
  // Simulation report when the sticky error first rises.
  always_ff @(posedge clk_i) begin
    if (err_report_p && reset_i && w_err_set && !r_error)
      $error("bsg_cache_nb_dma_initiator: DMA protocol error");
  end
`endif

endmodule

// File: tb/tb_bsg_cache_nb_dma_initiator.sv
// Self-checking bench for bsg_cache_nb_dma_initiator: directed scenarios plus
// randomized refill/evict traffic checked against a pending-set model.
module tb_bsg_cache_nb_dma_initiator;
  localparam int AW = 32, MW = 8, IW = 2, DW = 64, NB = 4, NM = 4;
  localparam int PW = AW + MW + IW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_i;
  logic          cmd_v_i, cmd_ready_o, cmd_write_i;
  logic [AW-1:0] cmd_addr_i;
  logic [MW-1:0] cmd_mask_i;
  logic [IW-1:0] cmd_mshr_id_i;
  logic [PW-1:0] dma_read_pkt_o, dma_write_pkt_o;
  logic          dma_read_pkt_v_o, dma_read_pkt_yumi_i;
  logic          dma_write_pkt_v_o, dma_write_pkt_yumi_i;
  logic [DW-1:0] dma_data_i, dma_data_o, evict_data_i, fill_data_o;
  logic [IW-1:0] dma_mshr_id_i, fill_mshr_id_o;
  logic          dma_data_v_i, dma_data_ready_o, dma_data_v_o, dma_data_yumi_i;
  logic          evict_data_v_i, evict_data_yumi_o;
  logic [1:0]    fill_burst_idx_o;
  logic          fill_last_o, fill_v_o, fill_ready_i;
  logic [NM-1:0] pending_o;
  logic          error_o;

  bsg_cache_nb_dma_initiator #(.err_report_p(1'b0)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .cmd_v_i(cmd_v_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i), .cmd_mask_i(cmd_mask_i), .cmd_mshr_id_i(cmd_mshr_id_i),
    .dma_read_pkt_o(dma_read_pkt_o), .dma_read_pkt_v_o(dma_read_pkt_v_o),
    .dma_read_pkt_yumi_i(dma_read_pkt_yumi_i),
    .dma_write_pkt_o(dma_write_pkt_o), .dma_write_pkt_v_o(dma_write_pkt_v_o),
    .dma_write_pkt_yumi_i(dma_write_pkt_yumi_i),
    .dma_data_i(dma_data_i), .dma_mshr_id_i(dma_mshr_id_i), .dma_data_v_i(dma_data_v_i),
    .dma_data_ready_o(dma_data_ready_o),
    .dma_data_o(dma_data_o), .dma_data_v_o(dma_data_v_o), .dma_data_yumi_i(dma_data_yumi_i),
    .evict_data_i(evict_data_i), .evict_data_v_i(evict_data_v_i),
    .evict_data_yumi_o(evict_data_yumi_o),
    .fill_data_o(fill_data_o), .fill_mshr_id_o(fill_mshr_id_o),
    .fill_burst_idx_o(fill_burst_idx_o), .fill_last_o(fill_last_o),
    .fill_v_o(fill_v_o), .fill_ready_i(fill_ready_i),
    .pending_o(pending_o), .error_o(error_o)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit m_pend [NM];   // reference: which MSHRs have a refill outstanding

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NM-1:0] pend_vec();
    logic [NM-1:0] v = '0;
    for (int i = 0; i < NM; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic logic [DW-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic zero_inputs();
    cmd_v_i = 0; cmd_write_i = 0; cmd_addr_i = '0; cmd_mask_i = '0; cmd_mshr_id_i = '0;
    dma_read_pkt_yumi_i = 0; dma_write_pkt_yumi_i = 0;
    dma_data_i = '0; dma_mshr_id_i = '0; dma_data_v_i = 0; fill_ready_i = 0;
    dma_data_yumi_i = 0; evict_data_i = '0; evict_data_v_i = 0;
  endtask

  // Reset with every request/response input active, checking all handshakes stay low.
  task automatic do_reset();
    reset_i = 0;
    cmd_v_i = 1; cmd_write_i = 1; dma_data_v_i = 1; fill_ready_i = 1;
    evict_data_v_i = 1; dma_data_yumi_i = 1;
    for (int i = 0; i < NM; i++) m_pend[i] = 0;
    sample();
    check("rst_cmd_ready", cmd_ready_o, 0);
    check("rst_fill_v", fill_v_o, 0);
    check("rst_data_ready", dma_data_ready_o, 0);
    step(); step();
    reset_i = 1;
    sample();
    check("post_rst_cmd_ready", cmd_ready_o, 0);
    check("post_rst_fill_v", fill_v_o, 0);
    check("post_rst_data_ready", dma_data_ready_o, 0);
    check("post_rst_evict_yumi", evict_data_yumi_o, 0);
    check("post_rst_rd_v", dma_read_pkt_v_o, 0);
    check("post_rst_wr_v", dma_write_pkt_v_o, 0);
    check("post_rst_pending", pending_o, 0);
    check("post_rst_error", error_o, 0);
    check("post_rst_idx", fill_burst_idx_o, 0);
    zero_inputs();
    step();
  endtask

  task automatic issue_cmd(input bit wr, input logic [AW-1:0] addr,
                           input logic [MW-1:0] mask, input logic [IW-1:0] id);
    bit ok = 0;
    cmd_v_i = 1; cmd_write_i = wr; cmd_addr_i = addr; cmd_mask_i = mask; cmd_mshr_id_i = id;
    for (int c = 0; c < 50 && !ok; c++) begin
      sample();
      if (cmd_ready_o) ok = 1;
      step();
    end
    if (!ok) check("cmd_accept_timeout", 0, 1);
    cmd_v_i = 0;
  endtask

  task automatic read_pkt(input logic [AW-1:0] addr, input logic [IW-1:0] id, input int delay);
    logic [PW-1:0] exp = {addr, {MW{1'b0}}, id};
    for (int d = 0; d < delay; d++) begin
      sample();
      check("rd_pkt_v_hold", dma_read_pkt_v_o, 1);
      check("rd_pkt_hold", dma_read_pkt_o, exp);
      step();
    end
    dma_read_pkt_yumi_i = 1;
    sample();
    check("rd_pkt_v", dma_read_pkt_v_o, 1);
    check("rd_pkt", dma_read_pkt_o, exp);
    step();
    dma_read_pkt_yumi_i = 0;
    m_pend[id] = 1;
    sample();
    check("rd_pending", pending_o, pend_vec());
    check("rd_pkt_v_drop", dma_read_pkt_v_o, 0);
    step();
  endtask

  task automatic write_pkt(input logic [AW-1:0] addr, input logic [MW-1:0] mask, input int delay);
    logic [PW-1:0] exp = {addr, mask, {IW{1'b0}}};
    cmd_write_i = 1;
    for (int d = 0; d <= delay; d++) begin
      if (d == delay) dma_write_pkt_yumi_i = 1;
      sample();
      check("wr_pkt_v", dma_write_pkt_v_o, 1);
      check("wr_pkt", dma_write_pkt_o, exp);
      check("wr_busy", cmd_ready_o, 0);
      step();
    end
    dma_write_pkt_yumi_i = 0;
  endtask

  // Evict stream: gapped 1-of-2 (rnd=0) or random valid/yumi (rnd=1).
  task automatic evict_data(input bit rnd);
    int k = 0;
    cmd_write_i = 1;
    for (int c = 0; c < 200 && k < NB; c++) begin
      evict_data_v_i  = rnd ? 1'($urandom_range(0, 1)) : 1'(c % 2);
      evict_data_i    = rnd64();
      dma_data_yumi_i = evict_data_v_i & (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      sample();
      check("ev_v", dma_data_v_o, evict_data_v_i);
      check("ev_data", dma_data_o, evict_data_i);
      check("ev_yumi", evict_data_yumi_o, dma_data_yumi_i);
      check("ev_busy", cmd_ready_o, 0);
      if (dma_data_yumi_i) k++;
      step();
    end
    if (k < NB) check("ev_timeout", k, NB);
    evict_data_v_i = 1; dma_data_yumi_i = 1;
    sample();
    check("ev_done_v", dma_data_v_o, 0);
    check("ev_done_yumi", evict_data_yumi_o, 0);
    check("ev_done_idle", cmd_ready_o, 1);
    evict_data_v_i = 0; dma_data_yumi_i = 0;
    step();
  endtask

  // Deliver nb bursts of a block for id; watch=1 checks cmd_ready against the model each cycle.
  task automatic return_block(input logic [IW-1:0] id, input bit rnd, input bit watch, input int nb);
    int k = 0;
    for (int c = 0; c < 300 && k < nb; c++) begin
      dma_data_v_i  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      dma_data_i    = rnd64();
      dma_mshr_id_i = id;
      fill_ready_i  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      sample();
      check("fill_v", fill_v_o, dma_data_v_i);
      check("fill_data", fill_data_o, dma_data_i);
      check("fill_id", fill_mshr_id_o, id);
      check("fill_ready", dma_data_ready_o, fill_ready_i);
      check("fill_idx", fill_burst_idx_o, k % NB);
      check("fill_last", fill_last_o, (k % NB) == NB - 1);
      if (watch) check("cmd_ready_blocked", cmd_ready_o, !m_pend[cmd_mshr_id_i]);
      if (dma_data_v_i && fill_ready_i) k++;
      step();
    end
    if (k < nb) check("fill_timeout", k, nb);
    dma_data_v_i = 0; fill_ready_i = 0;
    if (nb == NB) m_pend[id] = 0;
    sample();
    check("fill_pending", pending_o, pend_vec());
    check("fill_error", error_o, 0);
    step();
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [AW-1:0] a;
    logic [IW-1:0] id;
    zero_inputs();
    reset_i = 0;
    do_reset();
    sample();
    cmd_write_i = 1;
    #1 check("idle_ready", cmd_ready_o, 1);
    cmd_write_i = 0;
    step();

    // Refill 0x1000 id 2, packet taken after 3 cycles.
    issue_cmd(0, 32'h1000, '0, 2);
    read_pkt(32'h1000, 2, 3);
    check("pend_id2", pending_o, 4'b0100);
    return_block(2, 0, 0, NB);

    // Evict 0x2040 mask F0, gapped data.
    issue_cmd(1, 32'h2040, 8'hF0, 0);
    write_pkt(32'h2040, 8'hF0, 2);
    evict_data(0);

    // Refills 0, 1, 3 back to back; a second refill to id 1 waits for its block.
    issue_cmd(0, 32'h3000, '0, 0); read_pkt(32'h3000, 0, 0);
    issue_cmd(0, 32'h3020, '0, 1); read_pkt(32'h3020, 1, 1);
    issue_cmd(0, 32'h3060, '0, 3); read_pkt(32'h3060, 3, 0);
    check("pend_013", pending_o, 4'b1011);
    cmd_write_i = 0; cmd_mshr_id_i = 1;
    return_block(0, 1, 1, NB);
    return_block(3, 1, 1, NB);
    return_block(1, 1, 1, NB);
    cmd_write_i = 0; cmd_mshr_id_i = 1;
    sample();
    check("id1_ready_again", cmd_ready_o, 1);
    step();
    issue_cmd(0, 32'h3020, '0, 1); read_pkt(32'h3020, 1, 0);
    return_block(1, 1, 0, NB);

    // Randomized refill/evict traffic.
    for (int it = 0; it < 12; it++) begin
      a  = $urandom() & ~32'h1F;
      id = IW'($urandom_range(0, NM - 1));
      if ($urandom_range(0, 1) == 0) begin
        issue_cmd(0, a, '0, id);
        read_pkt(a, id, $urandom_range(0, 4));
        return_block(id, 1, 0, NB);
      end else begin
        cmd_mask_i = MW'($urandom());
        issue_cmd(1, a, cmd_mask_i, id);
        write_pkt(a, cmd_mask_i, $urandom_range(0, 3));
        evict_data(1);
      end
    end

    // Burst for an MSHR that is not pending: sticky error.
    dma_data_v_i = 1; dma_mshr_id_i = 3; dma_data_i = rnd64(); fill_ready_i = 1;
    sample();
    check("err_before", error_o, 0);
    step();
    dma_data_v_i = 0; fill_ready_i = 0;
    sample();
    check("err_rise", error_o, 1);
    step(); step(); step();
    sample();
    check("err_sticky", error_o, 1);
    step();
    do_reset();

    // Reset in the middle of a block abandons it.
    issue_cmd(0, 32'h4000, '0, 0); read_pkt(32'h4000, 0, 0);
    return_block(0, 0, 0, 2);
    dma_data_v_i = 1; dma_mshr_id_i = 0; fill_ready_i = 1; dma_data_i = rnd64();
    sample();
    check("mid_idx2", fill_burst_idx_o, 2);
    reset_i = 0;
    #1 check("mid_rst_fill_v", fill_v_o, 0);
    step();
    for (int i = 0; i < NM; i++) m_pend[i] = 0;
    sample();
    check("mid_rst_pending", pending_o, 0);
    check("mid_rst_idx", fill_burst_idx_o, 0);
    check("mid_rst_rd_v", dma_read_pkt_v_o, 0);
    check("mid_rst_ready", dma_data_ready_o, 0);
    step();
    do_reset();
    issue_cmd(0, 32'h5000, '0, 0); read_pkt(32'h5000, 0, 1);
    return_block(0, 1, 0, NB);
    check("final_pending", pending_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
